// File: rtl/arm_pkg.sv
// Shared encodings and helpers for the single-cycle ARM core.
package arm_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'h0, CondNe = 4'h1, CondCs = 4'h2, CondCc = 4'h3,
    CondMi = 4'h4, CondPl = 4'h5, CondVs = 4'h6, CondVc = 4'h7,
    CondHi = 4'h8, CondLs = 4'h9, CondGe = 4'ha, CondLt = 4'hb,
    CondGt = 4'hc, CondLe = 4'hd, CondAl = 4'he, CondNv = 4'hf
  } cond_e;

  typedef enum logic [1:0] {AluAdd = 2'd0, AluSub = 2'd1, AluAnd = 2'd2, AluOrr = 2'd3} alu_ctrl_e;

  typedef enum logic [1:0] {ShLsl = 2'd0, ShLsr = 2'd1, ShAsr = 2'd2, ShRor = 2'd3} shift_e;

  typedef enum logic [1:0] {OpDp = 2'b00, OpMem = 2'b01, OpBr = 2'b10, OpUndef = 2'b11} op_class_e;

  // Source of the ALU's second operand
  typedef enum logic [1:0] {Src2RotImm = 2'd0, Src2ShiftReg = 2'd1, Src2Imm12 = 2'd2} src2_sel_e;

  localparam logic [3:0] DpAnd = 4'b0000;
  localparam logic [3:0] DpSub = 4'b0010;
  localparam logic [3:0] DpAdd = 4'b0100;
  localparam logic [3:0] DpCmp = 4'b1010;
  localparam logic [3:0] DpCmn = 4'b1011;
  localparam logic [3:0] DpOrr = 4'b1100;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic cond_holds(input logic [3:0] cond, input nzcv_t f);
    logic ok;
    ok = 1'b0;
    unique case (cond_e'(cond))
      CondEq: ok = f.z;
      CondNe: ok = !f.z;
      CondCs: ok = f.c;
      CondCc: ok = !f.c;
      CondMi: ok = f.n;
      CondPl: ok = !f.n;
      CondVs: ok = f.v;
      CondVc: ok = !f.v;
      CondHi: ok = f.c && !f.z;
      CondLs: ok = !f.c || f.z;
      CondGe: ok = (f.n == f.v);
      CondLt: ok = (f.n != f.v);
      CondGt: ok = !f.z && (f.n == f.v);
      CondLe: ok = f.z || (f.n != f.v);
      CondAl: ok = 1'b1;
      CondNv: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Rotate right; a zero amount leaves the value unchanged
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] s);
    return (x >> s) | (x << (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/arm_alu.sv
// Barrel shifter, 32-bit ALU and NZCV generation.
module arm_alu
  import arm_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] rm_val,
  input  logic [11:0] operand,
  input  src2_sel_e   src2_sel,
  input  alu_ctrl_e   alu_ctrl,
  input  nzcv_t       flags_in,
  output logic [31:0] result,
  output nzcv_t       flags_out
);

  logic [31:0] src_b;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic [4:0]  shamt;
  logic        is_sub;

  // Second operand: rotated immediate, immediate-shifted register or raw offset
  always_comb begin
    shamt = operand[11:7];
    src_b = '0;
    unique case (src2_sel)
      Src2RotImm:   src_b = ror32({24'b0, operand[7:0]}, {operand[11:8], 1'b0});
      Src2ShiftReg: begin
        unique case (shift_e'(operand[6:5]))
          ShLsl: src_b = rm_val << shamt;
          ShLsr: src_b = rm_val >> shamt;
          ShAsr: src_b = $unsigned($signed(rm_val) >>> shamt);
          ShRor: src_b = ror32(rm_val, shamt);
        endcase
      end
      Src2Imm12:    src_b = {20'b0, operand};
      default:      src_b = '0;
    endcase
  end

  // Subtract is a + ~b + 1 so the carry-out is the ARM NOT-borrow
  always_comb begin
    is_sub = (alu_ctrl == AluSub);
    b_eff  = is_sub ? ~src_b : src_b;
    sum    = {1'b0, src_a} + {1'b0, b_eff} + {32'b0, is_sub};
    result = '0;
    unique case (alu_ctrl)
      AluAdd, AluSub: result = sum[31:0];
      AluAnd:         result = src_a & src_b;
      AluOrr:         result = src_a | src_b;
    endcase
    flags_out.n = result[31];
    flags_out.z = (result == '0);
    flags_out.c = flags_in.c;
    flags_out.v = flags_in.v;
    if (alu_ctrl == AluAdd || alu_ctrl == AluSub) begin
      flags_out.c = sum[32];
      flags_out.v = (src_a[31] == b_eff[31]) && (sum[31] != src_a[31]);
    end
  end

endmodule

// File: rtl/arm_core.sv
// Single-cycle ARMv4 integer-subset core: decode, condition check, register file, PC.
module arm_core
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] ReadData,
  output logic        MemWrite,
  output logic [31:0] PC,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData
);

  logic [31:0] pc_q, pc_next, pc_plus4, pc_plus8, br_target, wb_data;
  logic [31:0] rf_q [15];
  logic [31:0] rn_val, rm_val, rd_val;
  logic [3:0]  rn, rd, rm;
  nzcv_t       nzcv_q, alu_flags;
  logic        active, is_dp, is_mem, is_br, dp_writes, dp_sets_flags;
  logic        rf_we, flag_we, link_we;
  alu_ctrl_e   alu_ctrl;
  src2_sel_e   src2_sel;

  assign PC        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_plus8  = pc_q + 32'd8;
  assign rn        = Instr[19:16];
  assign rd        = Instr[15:12];
  assign rm        = Instr[3:0];
  assign WriteData = rd_val;

  // Register reads; R15 is not stored and reads as PC+8
  always_comb begin
    rn_val = (rn == 4'd15) ? pc_plus8 : rf_q[rn];
    rm_val = (rm == 4'd15) ? pc_plus8 : rf_q[rm];
    rd_val = (rd == 4'd15) ? pc_plus8 : rf_q[rd];
  end

  // Instruction decode; unsupported forms leave every is_* flag low (NOP)
  always_comb begin
    is_dp         = 1'b0;
    is_mem        = 1'b0;
    is_br         = 1'b0;
    dp_writes     = 1'b0;
    dp_sets_flags = 1'b0;
    alu_ctrl      = AluAdd;
    src2_sel      = Instr[25] ? Src2RotImm : Src2ShiftReg;
    unique case (op_class_e'(Instr[27:26]))
      OpDp: begin
        // Register-specified shifts are not supported
        if (Instr[25] || !Instr[4]) begin
          case (Instr[24:21])
            DpAnd: begin is_dp = 1'b1; dp_writes = 1'b1; alu_ctrl = AluAnd; end
            DpSub: begin is_dp = 1'b1; dp_writes = 1'b1; alu_ctrl = AluSub; end
            DpAdd: begin is_dp = 1'b1; dp_writes = 1'b1; alu_ctrl = AluAdd; end
            DpOrr: begin is_dp = 1'b1; dp_writes = 1'b1; alu_ctrl = AluOrr; end
            DpCmp: begin is_dp = 1'b1; dp_sets_flags = 1'b1; alu_ctrl = AluSub; end
            DpCmn: begin is_dp = 1'b1; dp_sets_flags = 1'b1; alu_ctrl = AluAdd; end
            default: ;
          endcase
          if (Instr[20] && dp_writes) dp_sets_flags = 1'b1;
        end
      end
      OpMem: begin
        src2_sel = Src2Imm12;
        alu_ctrl = Instr[23] ? AluAdd : AluSub;
        // Offset addressing only: P=1, B=0, W=0, immediate offset
        is_mem   = !Instr[25] && Instr[24] && !Instr[22] && !Instr[21];
      end
      OpBr:    is_br = Instr[25];
      default: ;
    endcase
  end

  // Write enables, store strobe and next-PC selection
  always_comb begin
    active    = cond_holds(Instr[31:28], nzcv_q) && !RESET;
    wb_data   = is_mem ? ReadData : ALUResult;
    rf_we     = active && ((is_dp && dp_writes) || (is_mem && Instr[20]));
    flag_we   = active && is_dp && dp_sets_flags;
    MemWrite  = active && is_mem && !Instr[20];
    link_we   = active && is_br && Instr[24];
    br_target = pc_plus8 + {{6{Instr[23]}}, Instr[23:0], 2'b00};
    pc_next   = pc_plus4;
    if (active && is_br) begin
      pc_next = br_target;
    end else if (rf_we && rd == 4'd15) begin
      pc_next = wb_data;
    end
  end

  arm_alu u_alu (
    .src_a    (rn_val),
    .rm_val   (rm_val),
    .operand  (Instr[11:0]),
    .src2_sel (src2_sel),
    .alu_ctrl (alu_ctrl),
    .flags_in (nzcv_q),
    .result   (ALUResult),
    .flags_out(alu_flags)
  );

  // Architectural state: PC, R0-R14, NZCV
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q   <= RESET_PC;
      nzcv_q <= '0;
      for (int i = 0; i < 15; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_next;
      if (rf_we && rd != 4'd15) rf_q[rd] <= wb_data;
      if (link_we) rf_q[14] <= pc_plus4;
      if (flag_we) nzcv_q <= alu_flags;
    end
  end

endmodule

// File: tb/tb_arm_core.sv
// Self-checking bench for arm_core: directed program table, corner sequences, random stream.
module tb_arm_core;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] Instr = '0;
  logic [31:0] ReadData = '0;
  logic        MemWrite;
  logic [31:0] PC, ALUResult, WriteData;

  arm_core #(.RESET_PC(32'h0)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Instr    (Instr),
    .ReadData (ReadData),
    .MemWrite (MemWrite),
    .PC       (PC),
    .ALUResult(ALUResult),
    .WriteData(WriteData)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_r [15];
  logic [31:0] m_pc = '0;
  logic        m_n = 0, m_z = 0, m_c = 0, m_v = 0;
  logic        pc_valid = 1'b0;

  logic [31:0] obs_alu, obs_wd;
  logic        obs_mw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [3:0] i);
    return (i == 4'd15) ? m_pc + 32'd8 : m_r[i];
  endfunction

  function automatic logic m_cond(input logic [3:0] c);
    case (c)
      4'd0:  return m_z;
      4'd1:  return !m_z;
      4'd2:  return m_c;
      4'd3:  return !m_c;
      4'd4:  return m_n;
      4'd5:  return !m_n;
      4'd6:  return m_v;
      4'd7:  return !m_v;
      4'd8:  return m_c && !m_z;
      4'd9:  return !m_c || m_z;
      4'd10: return m_n == m_v;
      4'd11: return m_n != m_v;
      4'd12: return !m_z && (m_n == m_v);
      4'd13: return m_z || (m_n != m_v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Bitwise rotate / arithmetic shift, one position at a time
  function automatic logic [31:0] m_ror(input logic [31:0] x, input int s);
    logic [31:0] r = x;
    for (int k = 0; k < s; k++) r = {r[0], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] m_asr(input logic [31:0] x, input int s);
    logic [31:0] r = x;
    for (int k = 0; k < s; k++) r = {r[31], r[31:1]};
    return r;
  endfunction

  task automatic model_step(input logic [31:0] ins, input logic [31:0] rdat, input logic rst,
                            output logic alu_chk, output logic [31:0] e_alu,
                            output logic [31:0] e_wd, output logic e_mw);
    logic [3:0]  rd, op4;
    logic [31:0] a, b, res, npc;
    logic        pass, wr, sub, arith;
    longint      sr;
    int          off;
    alu_chk = 1'b0; e_alu = '0; e_mw = 1'b0;
    e_wd = m_reg(ins[15:12]);
    if (rst) begin
      m_pc = '0;
      for (int i = 0; i < 15; i++) m_r[i] = '0;
      {m_n, m_z, m_c, m_v} = 4'b0;
      return;
    end
    rd   = ins[15:12];
    op4  = ins[24:21];
    a    = m_reg(ins[19:16]);
    b    = '0;
    pass = m_cond(ins[31:28]);
    npc  = m_pc + 32'd4;
    if (ins[27:26] == 2'b00 && (ins[25] || !ins[4]) && (op4 inside {0, 2, 4, 12, 10, 11})) begin
      if (ins[25]) b = m_ror({24'b0, ins[7:0]}, 2 * int'(ins[11:8]));
      else begin
        case (ins[6:5])
          2'd0: b = m_reg(ins[3:0]) << ins[11:7];
          2'd1: b = m_reg(ins[3:0]) >> ins[11:7];
          2'd2: b = m_asr(m_reg(ins[3:0]), int'(ins[11:7]));
          default: b = m_ror(m_reg(ins[3:0]), int'(ins[11:7]));
        endcase
      end
      sub   = op4 inside {2, 10};
      arith = op4 inside {2, 4, 10, 11};
      if (op4 == 4'd0) res = a & b;
      else if (op4 == 4'd12) res = a | b;
      else if (sub) res = a - b;
      else res = a + b;
      alu_chk = pass;
      e_alu   = res;
      if (pass) begin
        wr = !(op4 inside {10, 11});
        if (ins[20] || !wr) begin
          m_n = res[31];
          m_z = (res == 32'd0);
          if (arith) begin
            if (sub) begin
              m_c = (a >= b);
              sr  = longint'($signed(a)) - longint'($signed(b));
            end else begin
              m_c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
              sr  = longint'($signed(a)) + longint'($signed(b));
            end
            m_v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
          end
        end
        if (wr) begin
          if (rd == 4'd15) npc = res;
          else m_r[rd] = res;
        end
      end
    end else if (ins[27:26] == 2'b01 && !ins[25] && ins[24] && !ins[22] && !ins[21]) begin
      res     = ins[23] ? a + {20'b0, ins[11:0]} : a - {20'b0, ins[11:0]};
      alu_chk = pass;
      e_alu   = res;
      if (pass) begin
        if (ins[20]) begin
          if (rd == 4'd15) npc = rdat;
          else m_r[rd] = rdat;
        end else begin
          e_mw = 1'b1;
        end
      end
    end else if (ins[27:25] == 3'b101 && pass) begin
      off = int'($signed(ins[23:0]));
      npc = m_pc + 32'd8 + 32'(off * 4);
      if (ins[24]) m_r[14] = m_pc + 32'd4;
    end
    m_pc = npc;
  endtask

  // One instruction: drive at negedge, compare mid-cycle, model advances
  task automatic step(input logic [31:0] ins, input logic [31:0] rdat, input logic rst,
                      input string tag);
    logic        chk, e_mw;
    logic [31:0] e_alu, e_wd;
    @(negedge CLK);
    if (pc_valid) check({tag, " pc"}, PC, m_pc);
    pc_valid = 1'b1;
    Instr    = ins;
    ReadData = rdat;
    RESET    = rst;
    #1;
    model_step(ins, rdat, rst, chk, e_alu, e_wd, e_mw);
    obs_alu = ALUResult;
    obs_wd  = WriteData;
    obs_mw  = MemWrite;
    check({tag, " memwrite"}, {31'b0, obs_mw}, {31'b0, e_mw});
    if (chk) check({tag, " aluresult"}, obs_alu, e_alu);
    if (e_mw) check({tag, " writedata"}, obs_wd, e_wd);
  endtask

  task automatic expect_pc(input string name, input logic [31:0] exp);
    @(posedge CLK);
    #1;
    check(name, PC, exp);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 9);
    if ($urandom_range(0, 3) != 0) w[31:28] = 4'he;
    if (k <= 4) begin
      w[27:26] = 2'b00;
      case ($urandom_range(0, 7))
        0: w[24:21] = 4'h0;
        1: w[24:21] = 4'h2;
        2: w[24:21] = 4'h4;
        3: w[24:21] = 4'hc;
        4: w[24:21] = 4'ha;
        5: w[24:21] = 4'hb;
        default: ;
      endcase
      if ($urandom_range(0, 7) != 0) w[4] = 1'b0;
      if ($urandom_range(0, 7) != 0 && w[15:12] == 4'hf) w[15:12] = 4'h0;
    end else if (k <= 6) begin
      w[27:24] = 4'b0101;
      w[22:21] = 2'b00;
      if ($urandom_range(0, 7) == 0) w[25:21] = 5'($urandom());
      if ($urandom_range(0, 7) != 0 && w[15:12] == 4'hf) w[15:12] = 4'h0;
    end else if (k == 7) begin
      w[27:25] = 3'b101;
    end else if (k == 8) begin
      w[27:25] = ($urandom_range(0, 1) != 0) ? 3'b100 : {2'b11, w[25]};
    end
    // Keep non-LSL immediate shifts at a non-zero amount
    if (w[27:25] == 3'b000 && !w[4] && w[6:5] != 2'b00 && w[11:7] == 5'd0) w[7] = 1'b1;
    return w;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] rdat;
    logic        chk_alu;
    logic [31:0] alu;
    logic        chk_wd;
    logic [31:0] wd;
    logic [31:0] pc_after;
  } vec_t;

  vec_t prog [13];

  initial begin
    prog[0]  = '{32'hE59F1204, 32'd5, 1'b1, 32'h20C, 1'b0, 32'd0,  32'h04};
    prog[1]  = '{32'hE59F2204, 32'd6, 1'b1, 32'h210, 1'b0, 32'd0,  32'h08};
    prog[2]  = '{32'hE59F9204, 32'd3, 1'b1, 32'h214, 1'b0, 32'd0,  32'h0C};
    prog[3]  = '{32'hE0815002, 32'd0, 1'b1, 32'd11,  1'b0, 32'd0,  32'h10};
    prog[4]  = '{32'hE0456009, 32'd0, 1'b1, 32'd8,   1'b0, 32'd0,  32'h14};
    prog[5]  = '{32'hE0817005, 32'd0, 1'b1, 32'd16,  1'b0, 32'd0,  32'h18};
    prog[6]  = '{32'hE0458002, 32'd0, 1'b1, 32'd5,   1'b0, 32'd0,  32'h1C};
    prog[7]  = '{32'hEAFFFFFE, 32'd0, 1'b0, 32'd0,   1'b0, 32'd0,  32'h1C};
    prog[8]  = '{32'hEAFFFFFE, 32'd0, 1'b0, 32'd0,   1'b0, 32'd0,  32'h1C};
    prog[9]  = '{32'hE5805000, 32'd0, 1'b1, 32'd0,   1'b1, 32'd11, 32'h20};
    prog[10] = '{32'hE5806000, 32'd0, 1'b1, 32'd0,   1'b1, 32'd8,  32'h24};
    prog[11] = '{32'hE5807000, 32'd0, 1'b1, 32'd0,   1'b1, 32'd16, 32'h28};
    prog[12] = '{32'hE5808000, 32'd0, 1'b1, 32'd0,   1'b1, 32'd5,  32'h2C};

    // Reset with a store on the bus: no strobe, PC to 0
    step(32'hE5801004, 32'd0, 1'b1, "reset0");
    check("reset0 memwrite", {31'b0, obs_mw}, 32'd0);
    expect_pc("reset0 pc", 32'h0);

    for (int i = 0; i < 13; i++) begin
      step(prog[i].ins, prog[i].rdat, 1'b0, "prog");
      if (prog[i].chk_alu) check($sformatf("prog[%0d] alu", i), obs_alu, prog[i].alu);
      if (prog[i].chk_wd) begin
        check($sformatf("prog[%0d] wd", i), obs_wd, prog[i].wd);
        check($sformatf("prog[%0d] mw", i), {31'b0, obs_mw}, 32'd1);
      end
      expect_pc($sformatf("prog[%0d] pc", i), prog[i].pc_after);
    end

    // STR R1,[R0,#4] with R0=0x800, R1=0x1234
    step(32'hE5801004, 32'd0, 1'b1, "reset1");
    step(32'hE2800B02, 32'd0, 1'b0, "str");
    check("mov r0 alu", obs_alu, 32'h800);
    step(32'hE2831C12, 32'd0, 1'b0, "str");
    step(32'hE2811034, 32'd0, 1'b0, "str");
    check("mov r1 alu", obs_alu, 32'h1234);
    step(32'hE5801004, 32'd0, 1'b0, "str");
    check("str mw", {31'b0, obs_mw}, 32'd1);
    check("str addr", obs_alu, 32'h804);
    check("str wd", obs_wd, 32'h1234);
    expect_pc("str pc", 32'h10);

    // CMP R1,R1 ; BEQ taken ; STRCS shows C=1
    step(32'hE1510001, 32'd0, 1'b0, "cmp");
    step(32'h0A000002, 32'd0, 1'b0, "beq");
    expect_pc("beq taken pc", 32'h24);
    step(32'h25800000, 32'd0, 1'b0, "strcs");
    check("carry after cmp eq", {31'b0, obs_mw}, 32'd1);
    // CMP R1,R2 (differ) ; BEQ falls through
    step(32'hE1510002, 32'd0, 1'b0, "cmp");
    step(32'h0A000002, 32'd0, 1'b0, "beq");
    expect_pc("beq not taken pc", 32'h30);

    // ADD R3,R1,R1,LSL #2 with R1=5
    step(32'hE2841005, 32'd0, 1'b0, "lsl");
    step(32'hE0813101, 32'd0, 1'b0, "lsl");
    check("add lsl alu", obs_alu, 32'd25);
    step(32'hE5803000, 32'd0, 1'b0, "lsl");
    check("r3 value", obs_wd, 32'd25);

    // ADDS 0x7FFFFFFF + 1 -> N=1, V=1
    step(32'hE2845102, 32'd0, 1'b0, "adds");
    step(32'hE2455001, 32'd0, 1'b0, "adds");
    check("r5 max pos", obs_alu, 32'h7FFF_FFFF);
    step(32'hE2956001, 32'd0, 1'b0, "adds");
    check("adds result", obs_alu, 32'h8000_0000);
    step(32'h45800000, 32'd0, 1'b0, "strmi");
    check("n set", {31'b0, obs_mw}, 32'd1);
    step(32'h65800000, 32'd0, 1'b0, "strvs");
    check("v set", {31'b0, obs_mw}, 32'd1);
    step(32'h55800000, 32'd0, 1'b0, "strpl");
    check("pl fails", {31'b0, obs_mw}, 32'd0);

    // Jump to 0x10, reset there, then registers and flags read zero
    step(32'hE284F010, 32'd0, 1'b0, "jmp");
    expect_pc("jump pc", 32'h10);
    step(32'hE5805000, 32'd0, 1'b1, "midreset");
    check("midreset mw", {31'b0, obs_mw}, 32'd0);
    expect_pc("midreset pc", 32'h0);
    step(32'h65800000, 32'd0, 1'b0, "post");
    check("v cleared", {31'b0, obs_mw}, 32'd0);
    step(32'h45800000, 32'd0, 1'b0, "post");
    check("n cleared", {31'b0, obs_mw}, 32'd0);
    step(32'hE5805000, 32'd0, 1'b0, "post");
    check("r5 cleared", obs_wd, 32'd0);

    // BL at 0x20 then return through R14
    step(32'hE284F020, 32'd0, 1'b0, "bl");
    expect_pc("to 0x20", 32'h20);
    step(32'hEB000002, 32'd0, 1'b0, "bl");
    expect_pc("bl target", 32'h30);
    step(32'hE28EF000, 32'd0, 1'b0, "ret");
    check("r14 link", obs_alu, 32'h24);
    expect_pc("return pc", 32'h24);

    // Random stream against the model
    for (int i = 0; i < 600; i++) begin
      step(rand_instr(), $urandom(), ($urandom_range(0, 63) == 0), "rand");
    end
    @(negedge CLK);
    check("final pc", PC, m_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_core.md
Name: arm_core

Overview:
- Single-cycle 32-bit ARMv4 integer-subset processor core. One instruction completes per CLK cycle.
- Sits inside the board-level memory wrapper, which supplies:
  - Instr, combinationally indexed by PC[8:2].
  - ReadData, combinationally decoded from ALUResult.
- The wrapper captures WriteData on the same CLK edge when MemWrite is high.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded by reset.

Ports:
- CLK, input, 1, system clock; all state updates on the rising edge.
- RESET, input, 1, synchronous, active-high reset.
- Instr, input, 32, instruction at the current PC.
- ReadData, input, 32, load data for the current ALUResult address.
- MemWrite, output, 1, store strobe for the current cycle.
- PC, output, 32, current instruction address (register).
- ALUResult, output, 32, ALU output; also the data-memory address.
- WriteData, output, 32, store data (the Rd value).

Behaviour:
- State:
  - PC register.
  - R0–R14 register file.
  - NZCV flag register.
  - R15 is not stored. Reading it as Rn, Rm or Rd yields PC+8.
- Reset, on the rising CLK edge with RESET high:
  - PC <= RESET_PC.
  - R0–R14 <= 0.
  - NZCV <= 0.
  - While RESET is high, MemWrite = 0 and no register or flag writes occur.
- Outputs:
  - ALUResult, WriteData and MemWrite are combinational from Instr, state and ReadData. There is no added latency.
- Condition field Instr[31:28]:
  - Full ARM set EQ..AL is evaluated against the flags.
  - 1111 counts as condition failed.
  - A failed condition suppresses the register write, the flag write, MemWrite and any branch. PC still advances by 4.
- Data processing (op=00):
  - Opcodes: AND 0000, SUB 0010, ADD 0100, ORR 1100; CMP 1010 and CMN 1011 set flags only.
  - All other opcodes are a NOP.
  - Src2 for I=1: imm8 rotated right by 2*rot4.
  - Src2 for I=0: Rm shifted by shamt5 using LSL, LSR, ASR or ROR. Register-specified shifts (Instr[4]=1) are a NOP.
  - S=1, or CMP/CMN, updates the flags:
    - ADD/SUB/CMP/CMN set N, Z, C and V. C is the carry-out; for subtract it is NOT borrow. V is signed overflow.
    - AND/ORR set N and Z only; C and V are unchanged.
- Memory (op=01):
  - Only offset addressing is supported: P=1, W=0, B=0, with a 12-bit immediate offset.
  - Address = Rn + imm12 when U=1, Rn - imm12 when U=0.
  - LDR (L=1): Rd <= ReadData at the edge.
  - STR (L=0): MemWrite=1 and WriteData = Rd.
  - Any other form of op=01 is a NOP.
- Branch (op=10, Instr[25]=1):
  - Target = PC + 8 + (sign-extended imm24 << 2).
  - BL (Instr[24]=1) additionally writes R14 <= PC + 4.
- Writes to R15:
  - A data-processing or LDR result with Rd=15 loads PC instead of the register file.
  - This overrides PC+4.
- Next PC: PC + 4 unless a branch or R15 write is taken.
- Undefined instruction classes: op=11, or op=10 with bit25=0, execute as a NOP with PC+4.
- Arithmetic is modulo 2^32 (wrap-around). Branch targets wrap modulo 2^32.

Decomposition:
- Shared package arm_pkg:
  - Condition-code constants.
  - ALU-control encoding: ADD, SUB, AND, ORR.
  - Shift-type encoding.
  - Instruction-class encodings: DP, MEM, BR.
- Natural sub-module: arm_alu, covering the barrel shifter, the ALU and NZCV generation.
- The decoder, condition logic and register file remain in arm_core.

Test Plan:
- Program with PC=0, Instr sequence E59F1204, E59F2204, E59F9204, E0815002, E0456009, E0817005, E0458002, EAFFFFFE; ReadData at 0x20C/0x210/0x214 = 5/6/3:
  - First three ALUResult values are 0x20C, 0x210, 0x214.
  - Final values: R5=11, R6=8, R7=16, R8=5.
  - PC then holds at 0x1C indefinitely.
- STR R1,[R0,#4] (E5801004) with R0=0x800, R1=0x1234 -> MemWrite=1, ALUResult=0x804, WriteData=0x1234, no register change.
- CMP R1,R1 then BEQ +8 -> Z=1, C=1 and the branch is taken. With R1≠R2 via CMP R1,R2 -> BEQ not taken, PC+4.
- ADD R3,R1,R1,LSL #2 with R1=5 -> R3=25. ADDS 0x7FFFFFFF+1 -> result 0x80000000, N=1, V=1.
- RESET asserted for 1 cycle mid-program at PC=0x10:
  - Next PC=0.
  - Registers and flags read 0.
  - MemWrite=0 during RESET.
- BL at PC=0x20 with imm24=0x000002 -> PC=0x30, R14=0x24. MOV-style ADD PC,R14,#0 then returns to 0x24.
